// File: rtl/frame_distributor.sv
// frame_distributor: drains a shared tagged-frame FIFO and steers each frame
// to any combination of six destination FIFOs (port0-3, arp, nic).
// Word format: [8] EOF, [7:0] byte. The first word of each frame is a routing
// tag whose low six bits select the destinations; the tag is never forwarded.
module frame_distributor #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst_n,
  input  logic [8:0]           src_dout,
  input  logic                 src_empty,
  output logic                 src_rd_en,
  output logic [8:0]           port0_din,
  output logic [8:0]           port1_din,
  output logic [8:0]           port2_din,
  output logic [8:0]           port3_din,
  output logic [8:0]           arp_din,
  output logic [8:0]           nic_din,
  input  logic                 port0_full,
  input  logic                 port1_full,
  input  logic                 port2_full,
  input  logic                 port3_full,
  input  logic                 arp_full,
  input  logic                 nic_full,
  output logic                 port0_wr_en,
  output logic                 port1_wr_en,
  output logic                 port2_wr_en,
  output logic                 port3_wr_en,
  output logic                 arp_wr_en,
  output logic                 nic_wr_en,
  output logic [CNT_WIDTH-1:0] frame_cnt,
  output logic [CNT_WIDTH-1:0] drop_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TAG  = 2'd1,
    ST_DATA = 2'd2,
    ST_DROP = 2'd3
  } state_t;

  state_t                state_r;
  logic                  run_r;
  logic                  inflight_r;
  logic                  hold_vld_r;
  logic [8:0]            hold_r;
  logic [5:0]            mask_r;
  logic [5:0]            wr_en_r;
  logic [8:0]            din_r;
  logic [CNT_WIDTH-1:0]  frame_cnt_r;
  logic [CNT_WIDTH-1:0]  drop_cnt_r;

  logic [5:0]            full_s;
  logic                  blocked_s;
  logic                  consume_s;
  logic                  write_s;
  logic                  rd_s;
  state_t                idle_nxt_s;

  // Saturating increment: counters stick at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  endfunction

  assign full_s = {nic_full, arp_full, port3_full, port2_full, port1_full, port0_full};

  // Decide whether the held word leaves this cycle and whether a new read may start.
  always_comb begin
    blocked_s = |(full_s & mask_r);
    consume_s = 1'b0;
    write_s   = 1'b0;
    case (state_r)
      ST_TAG:  consume_s = hold_vld_r;
      ST_DROP: consume_s = hold_vld_r;
      ST_DATA: begin
        // All-or-nothing multicast: one full selected port stalls every port.
        write_s   = hold_vld_r & ~blocked_s;
        consume_s = hold_vld_r & ~blocked_s;
      end
      default: consume_s = 1'b0;
    endcase
    // One word outstanding at most; run_r keeps the strobe low during reset.
    rd_s = run_r & ~src_empty & ~inflight_r & (~hold_vld_r | consume_s);
    // A read launched while a frame ends is already the next frame's tag.
    idle_nxt_s = rd_s ? ST_TAG : ST_IDLE;
  end

  assign src_rd_en   = rd_s;
  assign port0_din   = din_r;
  assign port1_din   = din_r;
  assign port2_din   = din_r;
  assign port3_din   = din_r;
  assign arp_din     = din_r;
  assign nic_din     = din_r;
  assign port0_wr_en = wr_en_r[0];
  assign port1_wr_en = wr_en_r[1];
  assign port2_wr_en = wr_en_r[2];
  assign port3_wr_en = wr_en_r[3];
  assign arp_wr_en   = wr_en_r[4];
  assign nic_wr_en   = wr_en_r[5];
  assign frame_cnt   = frame_cnt_r;
  assign drop_cnt    = drop_cnt_r;

  // Read pipeline: track the in-flight read and capture its data into the hold register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      run_r      <= 1'b0;
      inflight_r <= 1'b0;
      hold_vld_r <= 1'b0;
      hold_r     <= 9'd0;
    end else begin
      run_r      <= 1'b1;
      inflight_r <= rd_s;
      if (inflight_r) begin
        hold_r     <= src_dout;
        hold_vld_r <= 1'b1;
      end else if (consume_s) begin
        hold_vld_r <= 1'b0;
      end
    end
  end

  // Frame FSM with registered write strobes, shared write data and counters.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r     <= ST_IDLE;
      mask_r      <= 6'd0;
      wr_en_r     <= 6'd0;
      din_r       <= 9'd0;
      frame_cnt_r <= {CNT_WIDTH{1'b0}};
      drop_cnt_r  <= {CNT_WIDTH{1'b0}};
    end else begin
      wr_en_r <= write_s ? mask_r : 6'd0;
      if (write_s) begin
        din_r <= hold_r;
      end
      case (state_r)
        ST_IDLE: begin
          if (rd_s) begin
            state_r <= ST_TAG;
          end
        end
        ST_TAG: begin
          if (hold_vld_r) begin
            if (hold_r[8]) begin
              drop_cnt_r <= sat_inc(drop_cnt_r);
              state_r    <= idle_nxt_s;
            end else if (hold_r[5:0] == 6'd0) begin
              drop_cnt_r <= sat_inc(drop_cnt_r);
              state_r    <= ST_DROP;
            end else begin
              mask_r  <= hold_r[5:0];
              state_r <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (write_s && hold_r[8]) begin
            frame_cnt_r <= sat_inc(frame_cnt_r);
            state_r     <= idle_nxt_s;
          end
        end
        ST_DROP: begin
          if (hold_vld_r && hold_r[8]) begin
            state_r <= idle_nxt_s;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_distributor.sv
// Directed self-checking bench for frame_distributor. A queue models the
// source FIFO; a monitor records every write as {wr_en vector, data}.
module tb_frame_distributor;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [8:0]  src_dout = 9'd0;
  logic        src_empty = 1'b1;
  logic        src_rd_en;
  logic [8:0]  port0_din, port1_din, port2_din, port3_din, arp_din, nic_din;
  logic        port0_full = 1'b0, port1_full = 1'b0, port2_full = 1'b0;
  logic        port3_full = 1'b0, arp_full = 1'b0, nic_full = 1'b0;
  logic        port0_wr_en, port1_wr_en, port2_wr_en, port3_wr_en, arp_wr_en, nic_wr_en;
  logic [15:0] frame_cnt, drop_cnt;

  logic [8:0]  src_q [$];
  logic [14:0] ev_q [$];
  logic [8:0]  din_a [6];
  int          checks = 0;
  int          errors = 0;
  int          rd_empty_cnt = 0;
  int          din_err_cnt = 0;

  always #5 sys_clk = ~sys_clk;

  assign din_a[0] = port0_din;
  assign din_a[1] = port1_din;
  assign din_a[2] = port2_din;
  assign din_a[3] = port3_din;
  assign din_a[4] = arp_din;
  assign din_a[5] = nic_din;

  frame_distributor #(.CNT_WIDTH(16)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .src_dout(src_dout), .src_empty(src_empty), .src_rd_en(src_rd_en),
    .port0_din(port0_din), .port1_din(port1_din), .port2_din(port2_din),
    .port3_din(port3_din), .arp_din(arp_din), .nic_din(nic_din),
    .port0_full(port0_full), .port1_full(port1_full), .port2_full(port2_full),
    .port3_full(port3_full), .arp_full(arp_full), .nic_full(nic_full),
    .port0_wr_en(port0_wr_en), .port1_wr_en(port1_wr_en), .port2_wr_en(port2_wr_en),
    .port3_wr_en(port3_wr_en), .arp_wr_en(arp_wr_en), .nic_wr_en(nic_wr_en),
    .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
  );

  // Source FIFO model: data appears the cycle after the read strobe.
  always @(posedge sys_clk) begin
    if (src_rd_en) begin
      if (src_q.size() == 0) rd_empty_cnt++;
      else src_dout <= src_q.pop_front();
    end
  end

  // Empty flag follows the queue occupancy.
  always @(negedge sys_clk) src_empty = (src_q.size() == 0);

  // Write monitor: record each write cycle and flag differing data across selected ports.
  always @(negedge sys_clk) begin : mon
    logic [5:0] w;
    logic [8:0] ds;
    logic       first;
    w = {nic_wr_en, arp_wr_en, port3_wr_en, port2_wr_en, port1_wr_en, port0_wr_en};
    ds = 9'd0;
    first = 1'b1;
    if (|w) begin
      for (int i = 0; i < 6; i++) begin
        if (w[i]) begin
          if (first) begin
            ds = din_a[i];
            first = 1'b0;
          end else if (din_a[i] !== ds) begin
            din_err_cnt++;
          end
        end
      end
      ev_q.push_back({w, ds});
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge sys_clk);
    #1;
  endtask

  task automatic push(input logic [8:0] w);
    src_q.push_back(w);
  endtask

  task automatic test_reset;
    logic [5:0] w;
    push(9'h001);
    tick(2);
    w = {nic_wr_en, arp_wr_en, port3_wr_en, port2_wr_en, port1_wr_en, port0_wr_en};
    checks++;
    if (src_rd_en !== 1'b0 || src_empty !== 1'b0) begin
      errors++; $display("FAIL reset_rd_en: got rd=%b empty=%b expected rd=0 empty=0", src_rd_en, src_empty);
    end
    checks++;
    if (w !== 6'd0) begin
      errors++; $display("FAIL reset_wr_en: got %b expected 000000", w);
    end
    checks++;
    if ((port0_din | port1_din | port2_din | port3_din | arp_din | nic_din) !== 9'd0) begin
      errors++; $display("FAIL reset_din: got nonzero din, expected all 0");
    end
    checks++;
    if (frame_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_cnt: got frame=%0d drop=%0d expected 0 0", frame_cnt, drop_cnt);
    end
    src_q.delete();
    tick(1);
    sys_rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_unicast;
    logic [14:0] exp [3];
    exp[0] = {6'b000001, 9'h0AA};
    exp[1] = {6'b000001, 9'h0BB};
    exp[2] = {6'b000001, 9'h1CC};
    ev_q.delete();
    push(9'h001); push(9'h0AA); push(9'h0BB); push(9'h1CC);
    tick(30);
    checks++;
    if (ev_q.size() != 3) begin
      errors++; $display("FAIL unicast_count: got %0d writes expected 3", ev_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (ev_q[i] !== exp[i]) begin
          errors++; $display("FAIL unicast_word%0d: got %h expected %h", i, ev_q[i], exp[i]);
        end
      end
    end
    checks++;
    if (frame_cnt !== 16'd1) begin
      errors++; $display("FAIL unicast_frame_cnt: got %0d expected 1", frame_cnt);
    end
  endtask

  task automatic test_multicast;
    logic [14:0] exp [2];
    exp[0] = {6'b110000, 9'h011};
    exp[1] = {6'b110000, 9'h122};
    ev_q.delete();
    push(9'h030); push(9'h011); push(9'h122);
    tick(30);
    checks++;
    if (ev_q.size() != 2) begin
      errors++; $display("FAIL multicast_count: got %0d writes expected 2", ev_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (ev_q[i] !== exp[i]) begin
          errors++; $display("FAIL multicast_word%0d: got %h expected %h", i, ev_q[i], exp[i]);
        end
      end
    end
    checks++;
    if (frame_cnt !== 16'd2 || din_err_cnt != 0) begin
      errors++; $display("FAIL multicast_frame_cnt: got frame=%0d din_err=%0d expected 2 0", frame_cnt, din_err_cnt);
    end
  endtask

  task automatic test_backpressure;
    logic [14:0] exp [4];
    int rd_cnt;
    exp[0] = {6'b000011, 9'h0D1};
    exp[1] = {6'b000011, 9'h0D2};
    exp[2] = {6'b000011, 9'h0D3};
    exp[3] = {6'b000011, 9'h1D4};
    ev_q.delete();
    push(9'h003); push(9'h0D1); push(9'h0D2); push(9'h0D3); push(9'h1D4);
    for (int i = 0; i < 40 && ev_q.size() == 0; i++) tick(1);
    checks++;
    if (ev_q.size() != 1) begin
      errors++; $display("FAIL bp_first_write: got %0d writes expected 1 before stall", ev_q.size());
    end
    port1_full = 1'b1;
    rd_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (src_rd_en) rd_cnt++;
    end
    checks++;
    if (ev_q.size() != 1) begin
      errors++; $display("FAIL bp_stall_writes: got %0d writes expected 1", ev_q.size());
    end
    checks++;
    if (rd_cnt != 0) begin
      errors++; $display("FAIL bp_stall_reads: got %0d reads expected 0", rd_cnt);
    end
    port1_full = 1'b0;
    tick(30);
    checks++;
    if (ev_q.size() != 4) begin
      errors++; $display("FAIL bp_count: got %0d writes expected 4", ev_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (ev_q[i] !== exp[i]) begin
          errors++; $display("FAIL bp_word%0d: got %h expected %h", i, ev_q[i], exp[i]);
        end
      end
    end
    checks++;
    if (frame_cnt !== 16'd3) begin
      errors++; $display("FAIL bp_frame_cnt: got %0d expected 3", frame_cnt);
    end
  endtask

  task automatic test_drops;
    ev_q.delete();
    push(9'h000); push(9'h001); push(9'h002); push(9'h103);
    tick(25);
    checks++;
    if (ev_q.size() != 0 || drop_cnt !== 16'd1) begin
      errors++; $display("FAIL drop_mask0: got writes=%0d drop=%0d expected 0 1", ev_q.size(), drop_cnt);
    end
    push(9'h104); push(9'h004); push(9'h1EE);
    tick(25);
    checks++;
    if (drop_cnt !== 16'd2) begin
      errors++; $display("FAIL drop_empty_frame: got drop=%0d expected 2", drop_cnt);
    end
    checks++;
    if (ev_q.size() != 1) begin
      errors++; $display("FAIL drop_next_count: got %0d writes expected 1", ev_q.size());
    end else if (ev_q[0] !== {6'b000100, 9'h1EE}) begin
      errors++; $display("FAIL drop_next_tag: got %h expected %h", ev_q[0], {6'b000100, 9'h1EE});
    end
    checks++;
    if (frame_cnt !== 16'd4) begin
      errors++; $display("FAIL drop_frame_cnt: got %0d expected 4", frame_cnt);
    end
  endtask

  task automatic test_back_to_back;
    logic [14:0] exp [4];
    exp[0] = {6'b000010, 9'h055};
    exp[1] = {6'b000010, 9'h166};
    exp[2] = {6'b001000, 9'h077};
    exp[3] = {6'b001000, 9'h188};
    ev_q.delete();
    push(9'h002); push(9'h055); push(9'h166);
    push(9'h008); push(9'h077); push(9'h188);
    tick(40);
    checks++;
    if (ev_q.size() != 4) begin
      errors++; $display("FAIL b2b_count: got %0d writes expected 4", ev_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (ev_q[i] !== exp[i]) begin
          errors++; $display("FAIL b2b_word%0d: got %h expected %h", i, ev_q[i], exp[i]);
        end
      end
    end
    checks++;
    if (frame_cnt !== 16'd6 || drop_cnt !== 16'd2) begin
      errors++; $display("FAIL b2b_cnt: got frame=%0d drop=%0d expected 6 2", frame_cnt, drop_cnt);
    end
    checks++;
    if (rd_empty_cnt != 0 || din_err_cnt != 0) begin
      errors++; $display("FAIL b2b_rd_empty: got rd_while_empty=%0d din_err=%0d expected 0 0", rd_empty_cnt, din_err_cnt);
    end
  endtask

  task automatic test_async_reset;
    logic [5:0] w;
    ev_q.delete();
    push(9'h001); push(9'h0A1); push(9'h0A2); push(9'h0A3); push(9'h0A4); push(9'h1A5);
    for (int i = 0; i < 40 && ev_q.size() == 0; i++) tick(1);
    checks++;
    if (port0_wr_en !== 1'b1) begin
      errors++; $display("FAIL arst_pre_write: got port0_wr_en=%b expected 1", port0_wr_en);
    end
    #2;
    sys_rst_n = 1'b0;
    #1;
    w = {nic_wr_en, arp_wr_en, port3_wr_en, port2_wr_en, port1_wr_en, port0_wr_en};
    checks++;
    if (w !== 6'd0 || src_rd_en !== 1'b0) begin
      errors++; $display("FAIL arst_strobes: got wr=%b rd=%b expected 000000 0", w, src_rd_en);
    end
    checks++;
    if (frame_cnt !== 16'd0 || drop_cnt !== 16'd0) begin
      errors++; $display("FAIL arst_cnt: got frame=%0d drop=%0d expected 0 0", frame_cnt, drop_cnt);
    end
    src_q.delete();
    tick(2);
    sys_rst_n = 1'b1;
    tick(2);
    ev_q.delete();
    push(9'h020); push(9'h1F0);
    tick(25);
    checks++;
    if (ev_q.size() != 1) begin
      errors++; $display("FAIL arst_after_count: got %0d writes expected 1", ev_q.size());
    end else if (ev_q[0] !== {6'b100000, 9'h1F0}) begin
      errors++; $display("FAIL arst_after_tag: got %h expected %h", ev_q[0], {6'b100000, 9'h1F0});
    end
    checks++;
    if (frame_cnt !== 16'd1 || drop_cnt !== 16'd0) begin
      errors++; $display("FAIL arst_after_cnt: got frame=%0d drop=%0d expected 1 0", frame_cnt, drop_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_unicast();
    test_multicast();
    test_backpressure();
    test_drops();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
